// File: rtl/alu_issue_ctrl.sv
// Issue controller that sits in front of a fixed-latency pipelined ALU.
// It tracks destination tags in flight, stalls or forwards on RAW hazards, and drives register file writeback.
package alu_issue_pkg;
  typedef enum logic [3:0] {
    ALUOP_ADD  = 4'd0,
    ALUOP_SUB  = 4'd1,
    ALUOP_SLL  = 4'd2,
    ALUOP_SLT  = 4'd3,
    ALUOP_SLTU = 4'd4,
    ALUOP_XOR  = 4'd5,
    ALUOP_SRL  = 4'd6,
    ALUOP_SRA  = 4'd7,
    ALUOP_OR   = 4'd8,
    ALUOP_AND  = 4'd9
  } aluop_e;
endpackage

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_issue_valid,
  output logic            o_issue_ready,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_use_imm,
  input  logic [3:0]      i_opsel,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_kill,
  output logic [XLEN-1:0] o_alu_op1,
  output logic [XLEN-1:0] o_alu_op2,
  output logic [3:0]      o_alu_opsel,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic [31:0]     o_stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } tag_t;

  tag_t            stage_q [1:ALU_LAT];
  tag_t            last_stage;
  logic [31:0]     stall_count_q;
  logic            use_rs2;
  logic            hazard;
  logic            fire;
  logic            fwd_rs1;
  logic            fwd_rs2;
  logic [XLEN-1:0] op1_res;
  logic [XLEN-1:0] op2_res;

  assign last_stage = stage_q[ALU_LAT];
  assign use_rs2    = !i_use_imm;

  // Only stages whose result has not yet reached the ALU output can cause a stall.
  always_comb begin
    // NOTE: default assigned before the loop so no path leaves hazard unassigned (no latch).
    hazard = 1'b0;
    for (int k = 1; k < ALU_LAT; k++) begin
      if (stage_q[k].valid) begin
        if (i_rs1_addr != 5'd0 && i_rs1_addr == stage_q[k].rd) hazard = 1'b1;
        if (use_rs2 && i_rs2_addr != 5'd0 && i_rs2_addr == stage_q[k].rd) hazard = 1'b1;
      end
    end
  end

  assign o_issue_ready = !hazard && !i_kill && !i_reset;
  assign fire          = i_issue_valid && o_issue_ready;

  // A valid entry never carries rd = 0, so x0 can never match here.
  assign fwd_rs1 = last_stage.valid && (i_rs1_addr == last_stage.rd);
  assign fwd_rs2 = last_stage.valid && use_rs2 && (i_rs2_addr == last_stage.rd);

  assign op1_res = fwd_rs1 ? i_alu_result : i_rs1_data;
  assign op2_res = i_use_imm ? i_imm : (fwd_rs2 ? i_alu_result : i_rs2_data);

  always_comb begin
    o_alu_op1   = '0;
    o_alu_op2   = '0;
    o_alu_opsel = ALUOP_ADD;
    if (fire) begin
      o_alu_op1   = op1_res;
      o_alu_op2   = op2_res;
      o_alu_opsel = i_opsel;
    end
  end

  // Writeback is held off while reset is asserted so nothing in flight reaches the register file.
  assign o_wb_valid    = last_stage.valid && !i_reset;
  assign o_wb_rd       = o_wb_valid ? last_stage.rd : 5'd0;
  assign o_wb_data     = o_wb_valid ? i_alu_result : '0;
  assign o_stall_count = stall_count_q;

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every stage shifts from its pre-edge neighbour.
    if (i_reset) begin
      for (int k = 1; k <= ALU_LAT; k++) stage_q[k] <= '0;
      stall_count_q <= '0;
    end else begin
      if (i_issue_valid && hazard && !i_kill) stall_count_q <= stall_count_q + 32'd1;
      if (i_kill) begin
        for (int k = 1; k <= ALU_LAT; k++) stage_q[k] <= '0;
      end else begin
        stage_q[1] <= fire ? tag_t'{valid: (i_rd_addr != 5'd0), rd: i_rd_addr} : '0;
        for (int k = 2; k <= ALU_LAT; k++) stage_q[k] <= stage_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a two-cycle behavioural ALU behind it.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int XLEN    = 32;
  localparam int ALU_LAT = 2;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_issue_valid;
  logic            o_issue_ready;
  logic [4:0]      i_rs1_addr;
  logic [4:0]      i_rs2_addr;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [XLEN-1:0] i_imm;
  logic            i_use_imm;
  logic [3:0]      i_opsel;
  logic [4:0]      i_rd_addr;
  logic            i_kill;
  logic [XLEN-1:0] o_alu_op1;
  logic [XLEN-1:0] o_alu_op2;
  logic [3:0]      o_alu_opsel;
  logic [XLEN-1:0] i_alu_result;
  logic            o_wb_valid;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic [31:0]     o_stall_count;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_ctrl #(.XLEN(XLEN), .ALU_LAT(ALU_LAT)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_issue_valid (i_issue_valid),
    .o_issue_ready (o_issue_ready),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .i_imm         (i_imm),
    .i_use_imm     (i_use_imm),
    .i_opsel       (i_opsel),
    .i_rd_addr     (i_rd_addr),
    .i_kill        (i_kill),
    .o_alu_op1     (o_alu_op1),
    .o_alu_op2     (o_alu_op2),
    .o_alu_opsel   (o_alu_opsel),
    .i_alu_result  (i_alu_result),
    .o_wb_valid    (o_wb_valid),
    .o_wb_rd       (o_wb_rd),
    .o_wb_data     (o_wb_data),
    .o_stall_count (o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural ALU: operands sampled at an edge appear on the result two edges later.
  function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, b, input logic [3:0] op);
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_SLL: return a << b[4:0];
      ALUOP_XOR: return a ^ b;
      ALUOP_OR:  return a | b;
      ALUOP_AND: return a & b;
      default:   return '0;
    endcase
  endfunction

  logic [XLEN-1:0] alu_p1 = '0;
  logic [XLEN-1:0] alu_p2 = '0;
  always @(posedge i_clk) begin
    alu_p1 <= alu_f(o_alu_op1, o_alu_op2, o_alu_opsel);
    alu_p2 <= alu_p1;
  end
  assign i_alu_result = alu_p2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic use_imm, input logic [3:0] op, input logic [4:0] rd);
    i_issue_valid = 1'b1;
    i_rs1_addr    = rs1;
    i_rs2_addr    = rs2;
    i_rs1_data    = d1;
    i_rs2_data    = d2;
    i_imm         = imm;
    i_use_imm     = use_imm;
    i_opsel       = op;
    i_rd_addr     = rd;
  endtask

  task automatic idle();
    offer(5'd0, 5'd0, '0, '0, '0, 1'b0, ALUOP_ADD, 5'd0);
    i_issue_valid = 1'b0;
  endtask

  task automatic sample();
    #4;
  endtask

  task automatic next();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] d);
    check({tag, "_wbv"}, {31'd0, o_wb_valid}, {31'd0, v});
    check({tag, "_wbrd"}, {27'd0, o_wb_rd}, {27'd0, rd});
    check({tag, "_wbd"}, o_wb_data, d);
  endtask

  initial begin
    i_reset = 1'b1;
    i_kill  = 1'b0;
    idle();
    next();
    offer(5'd1, 5'd2, 32'd3, 32'd4, '0, 1'b0, ALUOP_SUB, 5'd6);
    sample();
    check("rst_ready", {31'd0, o_issue_ready}, 32'd0);
    check("rst_op1", o_alu_op1, 32'd0);
    check("rst_opsel", {28'd0, o_alu_opsel}, {28'd0, ALUOP_ADD});
    check_wb("rst", 1'b0, 5'd0, 32'd0);
    check("rst_cnt", o_stall_count, 32'd0);
    next();
    i_reset = 1'b0;
    idle();
    next();

    // Independent stream, plus a double forward on the third instruction.
    offer(5'd10, 5'd11, 32'd5, 32'd7, '0, 1'b0, ALUOP_ADD, 5'd1);
    sample();
    check("ind_ready_a", {31'd0, o_issue_ready}, 32'd1);
    check("ind_op1_a", o_alu_op1, 32'd5);
    check("ind_op2_a", o_alu_op2, 32'd7);
    next();
    offer(5'd12, 5'd13, 32'hF0, 32'h0F, '0, 1'b0, ALUOP_XOR, 5'd2);
    sample();
    check("ind_ready_b", {31'd0, o_issue_ready}, 32'd1);
    check("ind_opsel_b", {28'd0, o_alu_opsel}, {28'd0, ALUOP_XOR});
    next();
    offer(5'd1, 5'd1, 32'd0, 32'd0, '0, 1'b0, ALUOP_ADD, 5'd9);
    sample();
    check_wb("ind_x1", 1'b1, 5'd1, 32'd12);
    check("dfwd_op1", o_alu_op1, 32'd12);
    check("dfwd_op2", o_alu_op2, 32'd12);
    next();
    idle();
    sample();
    check_wb("ind_x2", 1'b1, 5'd2, 32'hFF);
    check("ind_cnt", o_stall_count, 32'd0);
    next();

    // Back-to-back RAW: one stall cycle, then forwarded op1.
    offer(5'd14, 5'd15, 32'd10, 32'd1, '0, 1'b0, ALUOP_ADD, 5'd3);
    sample();
    check_wb("dfwd_x9", 1'b1, 5'd9, 32'd24);
    next();
    offer(5'd3, 5'd16, 32'd0, 32'd1, '0, 1'b0, ALUOP_SUB, 5'd4);
    sample();
    check("raw_ready_stall", {31'd0, o_issue_ready}, 32'd0);
    check("raw_bubble_op1", o_alu_op1, 32'd0);
    next();
    sample();
    check("raw_ready_go", {31'd0, o_issue_ready}, 32'd1);
    check("raw_fwd_op1", o_alu_op1, 32'd11);
    check("raw_op2", o_alu_op2, 32'd1);
    check_wb("raw_x3", 1'b1, 5'd3, 32'd11);
    next();
    idle();
    next();
    sample();
    check_wb("raw_x4", 1'b1, 5'd4, 32'd10);
    check("raw_cnt", o_stall_count, 32'd1);
    next();

    // Gap-of-one RAW: no stall, forwarded from the last stage.
    offer(5'd17, 5'd18, 32'h100, 32'd0, '0, 1'b0, ALUOP_ADD, 5'd5);
    next();
    idle();
    next();
    offer(5'd5, 5'd5, 32'd0, 32'd0, 32'd4, 1'b1, ALUOP_SLL, 5'd6);
    sample();
    check("gap_ready", {31'd0, o_issue_ready}, 32'd1);
    check("gap_fwd_op1", o_alu_op1, 32'h100);
    check("gap_op2_imm", o_alu_op2, 32'd4);
    next();
    idle();
    next();
    sample();
    check_wb("gap_x6", 1'b1, 5'd6, 32'h1000);
    next();

    // x0 destination and unused rs2.
    offer(5'd19, 5'd0, 32'd1, 32'd0, 32'd1, 1'b1, ALUOP_ADD, 5'd0);
    next();
    offer(5'd0, 5'd0, 32'd0, 32'd0, '0, 1'b0, ALUOP_ADD, 5'd7);
    sample();
    check("x0_ready", {31'd0, o_issue_ready}, 32'd1);
    next();
    offer(5'd20, 5'd21, 32'd3, 32'd4, '0, 1'b0, ALUOP_ADD, 5'd2);
    sample();
    check("x0_no_wb", {31'd0, o_wb_valid}, 32'd0);
    next();
    offer(5'd9, 5'd2, 32'h20, 32'd0, 32'd5, 1'b1, ALUOP_ADD, 5'd8);
    sample();
    check("imm_ready", {31'd0, o_issue_ready}, 32'd1);
    check_wb("x0_x7", 1'b1, 5'd7, 32'd0);
    next();
    idle();
    sample();
    check_wb("imm_x2", 1'b1, 5'd2, 32'd7);
    next();
    sample();
    check_wb("imm_x8", 1'b1, 5'd8, 32'h25);
    check("imm_cnt", o_stall_count, 32'd1);
    next();

    // Kill: older op still writes during the kill cycle, younger one is dropped.
    offer(5'd22, 5'd23, 32'd1, 32'd2, '0, 1'b0, ALUOP_ADD, 5'd1);
    next();
    offer(5'd24, 5'd25, 32'd4, 32'd4, '0, 1'b0, ALUOP_ADD, 5'd2);
    next();
    offer(5'd26, 5'd27, 32'd9, 32'd9, '0, 1'b0, ALUOP_ADD, 5'd9);
    i_kill = 1'b1;
    sample();
    check("kill_ready", {31'd0, o_issue_ready}, 32'd0);
    check("kill_bubble_op1", o_alu_op1, 32'd0);
    check_wb("kill_x1", 1'b1, 5'd1, 32'd3);
    next();
    i_kill = 1'b0;
    idle();
    sample();
    check("kill_x2_dropped", {31'd0, o_wb_valid}, 32'd0);
    next();
    sample();
    check("kill_quiet", {31'd0, o_wb_valid}, 32'd0);
    next();

    // Counter wrap: preset to all-ones, then two stall cycles.
    offer(5'd27, 5'd28, 32'd1, 32'd1, '0, 1'b0, ALUOP_ADD, 5'd10);
    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count_q;
    next();
    offer(5'd10, 5'd29, 32'd0, 32'd1, '0, 1'b0, ALUOP_SUB, 5'd11);
    sample();
    check("wrap_stall1", {31'd0, o_issue_ready}, 32'd0);
    check("wrap_preset", o_stall_count, 32'hFFFF_FFFF);
    next();
    sample();
    check("wrap_zero", o_stall_count, 32'd0);
    check("wrap_fwd1", o_alu_op1, 32'd2);
    next();
    offer(5'd11, 5'd11, 32'd0, 32'd0, 32'd3, 1'b1, ALUOP_ADD, 5'd12);
    sample();
    check("wrap_stall2", {31'd0, o_issue_ready}, 32'd0);
    next();
    sample();
    check("wrap_fwd2", o_alu_op1, 32'd1);
    check("wrap_one", o_stall_count, 32'd1);
    next();

    // Reset with ops in flight.
    offer(5'd30, 5'd31, 32'd1, 32'd1, '0, 1'b0, ALUOP_ADD, 5'd13);
    next();
    i_reset = 1'b1;
    offer(5'd14, 5'd15, 32'd1, 32'd1, '0, 1'b0, ALUOP_ADD, 5'd14);
    sample();
    check("rst2_ready", {31'd0, o_issue_ready}, 32'd0);
    check_wb("rst2_during", 1'b0, 5'd0, 32'd0);
    next();
    i_reset = 1'b0;
    idle();
    sample();
    check("rst2_after", {31'd0, o_wb_valid}, 32'd0);
    check("rst2_cnt", o_stall_count, 32'd0);
    next();
    sample();
    check("rst2_after2", {31'd0, o_wb_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the main ALU interface.
- Accepts decoded RV32I register/immediate ALU instructions through a valid/ready handshake, then drives op1/op2/opsel into the fixed-latency pipelined ALU.
- Tracks in-flight destination tags alongside the ALU pipeline and presents writeback when the result emerges.
- Resolves read-after-write hazards: stalls when the result is not yet available and forwards it from the writeback stage when it is.

Parameters:
- XLEN, 32: datapath width.
- ALU_LAT, 2: ALU latency in cycles, from operands sampled at a clock edge to result valid on `i_alu_result`. Supported range 2..4.

Ports:
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_issue_valid` in 1: instruction offered.
- `o_issue_ready` out 1: instruction accepted this cycle if `i_issue_valid` is also high.
- `i_rs1_addr` in 5: source 1 index.
- `i_rs2_addr` in 5: source 2 index; ignored when `i_use_imm` is high.
- `i_rs1_data` in XLEN: register file read data for rs1.
- `i_rs2_data` in XLEN: register file read data for rs2.
- `i_imm` in XLEN: sign-extended immediate.
- `i_use_imm` in 1: op2 comes from `i_imm`.
- `i_opsel` in 4: ALU operation, `ALUOP_*` encoding.
- `i_rd_addr` in 5: destination index.
- `i_kill` in 1: flush all in-flight operations.
- `o_alu_op1` out XLEN: to ALU `i_op1`.
- `o_alu_op2` out XLEN: to ALU `i_op2`.
- `o_alu_opsel` out 4: to ALU `i_opsel`.
- `i_alu_result` in XLEN: from ALU `o_aluout`.
- `o_wb_valid` out 1: register file write enable.
- `o_wb_rd` out 5: write index.
- `o_wb_data` out XLEN: write data.
- `o_stall_count` out 32: count of hazard-stall cycles.

Behaviour:
- Tag pipeline: ALU_LAT stages of {valid, rd}. Stage k holds the op issued k edges earlier; stage ALU_LAT aligns with `i_alu_result`. Every stage shifts each cycle; there is no backpressure.
- Fire: `fire = i_issue_valid & o_issue_ready`. On fire, stage 1 loads {1, `i_rd_addr`}; otherwise stage 1 loads {0, 0}.
- Effective rd: rd = 0 loads valid = 0. x0 never writes back and never causes a hazard.
- Source use: rs1 is always used; rs2 is used only when `i_use_imm` = 0.
- Hazard: a used source index is nonzero and equals the rd of a valid entry in stages 1..ALU_LAT-1.
- `o_issue_ready` = !hazard & !`i_kill` & !`i_reset`. It is combinational and does not depend on `i_issue_valid`.
- Forwarding: a used source matching a valid stage-ALU_LAT rd takes `i_alu_result`; otherwise it takes the register file data. A hazard always takes precedence, so the instruction stalls and forwarding is not used that cycle.
- op2 source: `i_imm` when `i_use_imm` = 1.
- ALU drive (combinational):
  - On fire, `o_alu_op1`/`o_alu_op2`/`o_alu_opsel` carry the resolved operands and `i_opsel`.
  - Otherwise they carry op1 = 0, op2 = 0, opsel = `ALUOP_ADD`, so bubbles never yield X from the ALU default case.
- Writeback (combinational from the last stage and `i_alu_result`):
  - `o_wb_valid` = stage-ALU_LAT valid.
  - `o_wb_rd` = stage rd when valid, else 0.
  - `o_wb_data` = `i_alu_result` when valid, else 0.
- Issue-to-writeback latency is exactly ALU_LAT cycles: fire in cycle t gives `o_wb_valid` in cycle t+ALU_LAT.
- Back-to-back dependence: with ALU_LAT = 2, a dependent instruction directly after its producer stalls exactly 1 cycle, then issues using the forwarded result.
- Kill: while `i_kill` is high there is no fire. At the next edge all stage valids clear, so no writeback occurs for ops in flight at that point. A result already at `o_wb_valid` during the kill cycle still writes (combinational, same cycle).
- Stall counter: increments on cycles with `i_issue_valid` & hazard & !`i_kill`. Wraps from 0xFFFFFFFF to 0.
- Reset (`i_reset` high at an edge):
  - All stage valids = 0, all stage rd = 0, `o_stall_count` = 0.
  - Outputs during and after reset: `o_wb_valid` = 0, `o_wb_rd` = 0, `o_wb_data` = 0, `o_issue_ready` = 0 while reset is asserted.
  - Reset mid-operation discards all in-flight ops; no writeback follows.
- Simultaneous forward match on rs1 and rs2 (same index): both take `i_alu_result`.

Test Plan:
- Independent stream: issue ADD x1 = 5+7, then XOR x2 = 0xF0^0x0F on consecutive cycles -> wb x1 = 12 at t+2, x2 = 0xFF at t+3; ready stays high; stall_count = 0.
- Back-to-back RAW: ADD x3 = 10+1, then immediately SUB x4 = x3-1 with stale rf x3 = 0 -> ready low 1 cycle; SUB issues with forwarded op1 = 11; wb x4 = 10; stall_count = 1.
- Gap-of-one RAW: ADD x5 = 0x100+0, bubble, then SLL x6 = x5 << imm 4 -> no stall; op1 forwarded = 0x100; wb x6 = 0x1000.
- x0 and immediate: ADDI x0 = 1+1, then ADD x7 = x0+x0 -> no wb for x0, no stall. Also ADDI x8 = x9+imm with stage-1 rd = x2 and rs2_addr field = 2 -> no stall, since rs2 is unused.
- Kill: issue ADD x1, ADD x2 back-to-back, assert `i_kill` the cycle after the second fires -> x1 wb occurs during the kill cycle; x2 wb is suppressed; ready low during kill.
- Reset/wrap: preload stall_count near 0xFFFFFFFF via a forced stall pattern, then stall 2 cycles -> count wraps to 1. Assert `i_reset` with ops in flight -> `o_wb_valid` stays 0; count = 0.
